mc_ctrl: RTL

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: the FETCH/DECODE/EXE/MEM/WB sequencer
// with combinational datapath selects and a retired-instruction counter.
module mc_ctrl #(
  parameter logic [1:0] EXT_ZERO = 2'b00,
  parameter logic [1:0] EXT_SIGN = 2'b01,
  parameter logic [1:0] EXT_LUI  = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pcwr,
  output logic        irwr,
  output logic        regwr,
  output logic        memwr,
  output logic [1:0]  extop,
  output logic        alusrc,
  output logic [2:0]  aluop,
  output logic [1:0]  regdst,
  output logic [1:0]  memtoreg,
  output logic [1:0]  npcsel,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 6;
  localparam int unsigned STW  = 3;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_JAL   = 6'b000011;
  localparam logic [OPW-1:0] FN_ADDU  = 6'b100001;
  localparam logic [OPW-1:0] FN_SUBU  = 6'b100011;
  localparam logic [OPW-1:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_PASS = 3'b011;

  typedef enum logic [STW-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    I_NOP, I_ADDU, I_SUBU, I_JR, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_J, I_JAL
  } iclass_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] retired_q;
  logic            retire_c;
  iclass_e         iclass_c;
  logic            unused_instr_c;

  assign unused_instr_c = ^instr[25:6];

  // Instruction classification from opcode/funct; anything unrecognised is a nop.
  always_comb begin
    iclass_c = I_NOP;
    case (instr[31:26])
      OP_RTYPE: begin
        case (instr[5:0])
          FN_ADDU: iclass_c = I_ADDU;
          FN_SUBU: iclass_c = I_SUBU;
          FN_JR:   iclass_c = I_JR;
          default: iclass_c = I_NOP;
        endcase
      end
      OP_ORI:  iclass_c = I_ORI;
      OP_LW:   iclass_c = I_LW;
      OP_SW:   iclass_c = I_SW;
      OP_BEQ:  iclass_c = I_BEQ;
      OP_LUI:  iclass_c = I_LUI;
      OP_J:    iclass_c = I_J;
      OP_JAL:  iclass_c = I_JAL;
      default: iclass_c = I_NOP;
    endcase
  end

  // Next-state and control outputs.
  always_comb begin
    state_d  = state_q;
    retire_c = 1'b0;
    pcwr     = 1'b0;
    irwr     = 1'b0;
    regwr    = 1'b0;
    memwr    = 1'b0;
    extop    = EXT_ZERO;
    alusrc   = 1'b0;
    aluop    = ALU_ADD;
    regdst   = 2'b00;
    memtoreg = 2'b00;
    npcsel   = 2'b00;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          irwr    = 1'b1;
          pcwr    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (iclass_c)
          I_J:   begin pcwr = 1'b1; npcsel = 2'b10; retire_c = 1'b1; state_d = S_FETCH; end
          I_JR:  begin pcwr = 1'b1; npcsel = 2'b11; retire_c = 1'b1; state_d = S_FETCH; end
          I_JAL: begin pcwr = 1'b1; npcsel = 2'b10; state_d = S_WB; end
          I_NOP: begin retire_c = 1'b1; state_d = S_FETCH; end
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        case (iclass_c)
          I_BEQ: begin
            aluop = ALU_SUB; npcsel = 2'b01; pcwr = zero;
            retire_c = 1'b1; state_d = S_FETCH;
          end
          I_LW, I_SW: begin aluop = ALU_ADD; alusrc = 1'b1; extop = EXT_SIGN; state_d = S_MEM; end
          I_ORI:  begin aluop = ALU_OR;   alusrc = 1'b1; extop = EXT_ZERO; state_d = S_WB; end
          I_LUI:  begin aluop = ALU_PASS; alusrc = 1'b1; extop = EXT_LUI;  state_d = S_WB; end
          I_ADDU: begin aluop = ALU_ADD; state_d = S_WB; end
          I_SUBU: begin aluop = ALU_SUB; state_d = S_WB; end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        extop  = EXT_SIGN;
        alusrc = 1'b1;
        case (iclass_c)
          I_SW: begin
            memwr = 1'b1;
            if (mem_ready) begin retire_c = 1'b1; state_d = S_FETCH; end
          end
          I_LW: if (mem_ready) state_d = S_WB;
          default: state_d = S_FETCH;
        endcase
      end
      S_WB: begin
        retire_c = 1'b1;
        state_d  = S_FETCH;
        case (iclass_c)
          I_ADDU, I_SUBU: begin regwr = 1'b1; regdst = 2'b01; end
          I_ORI: begin regwr = 1'b1; aluop = ALU_OR;   alusrc = 1'b1; extop = EXT_ZERO; end
          I_LUI: begin regwr = 1'b1; aluop = ALU_PASS; alusrc = 1'b1; extop = EXT_LUI;  end
          I_LW:  begin regwr = 1'b1; memtoreg = 2'b01; end
          I_JAL: begin regwr = 1'b1; regdst = 2'b10; memtoreg = 2'b10; end
          default: regwr = 1'b0;
        endcase
      end
      default: state_d = S_FETCH;
    endcase
    // Reset cycle: suppress every write and the retire count.
    if (reset) begin
      pcwr     = 1'b0;
      irwr     = 1'b0;
      regwr    = 1'b0;
      memwr    = 1'b0;
      retire_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_c) retired_q <= retired_q + XLEN'(1);
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule
